uart_rx_fsm: RTL and testbench
==============================

UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter OVERSAMPLE, default 16: sample ticks per bit period.
REQ-002 Parameter BITNUMBER, default 8: data bits per frame.
REQ-003 clk  input  1  system clock; one clock domain only.
REQ-004 rst  input  1  reset, asynchronous assert, active-low; released synchronously with clk.
REQ-005 p_SampleSig_i  input  1  oversample tick, one-clk pulse at OVERSAMPLE x baud rate.
REQ-006 Rx_i  input  1  serial line, asynchronous to clk, idle high.
REQ-007 ParityEnable_i  input  1  1 = a parity bit follows the data bits.
REQ-008 ParityOdd_i  input  1  1 = odd parity, 0 = even parity; ignored when parity is disabled.
REQ-009 State_o  output  5  one-hot state: IDLE 00001, STARTBIT 00010, DATABITS 00100, PARITYBIT 01000, STOPBIT 10000.
REQ-010 BitCounter_o  output  4  number of data bits received in the current frame.
REQ-011 Data_o  output  8  last good received byte, LSB first on the line.
REQ-012 p_DataValid_o  output  1  one-clk pulse when Data_o is updated.
REQ-013 p_ParityErr_o  output  1  one-clk pulse when the parity check fails.
REQ-014 p_FrameErr_o  output  1  one-clk pulse when the stop bit is sampled low.

Function
REQ-015 Rx_i SHALL pass through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rx_s.
REQ-016 Tick counter SHALL count p_SampleSig_i pulses within a bit, reset to 0 on every state change, and wrap at OVERSAMPLE-1.
REQ-017 Mid-bit sample point SHALL be the tick where the tick count equals OVERSAMPLE/2-1 in STARTBIT, and OVERSAMPLE-1 in all later states.
REQ-018 IDLE: a tick with rx_s=0 SHALL move the block to STARTBIT; otherwise it stays in IDLE.
REQ-019 STARTBIT: at the mid-bit sample, rx_s=0 SHALL move the block to DATABITS; rx_s=1 (false start) SHALL return it to IDLE with no pulse.
REQ-020 DATABITS: each sample SHALL shift rx_s into the MSB of the shift register (right shift) and increment the bit counter.
REQ-021 DATABITS: after sample number BITNUMBER the block SHALL go to PARITYBIT if ParityEnable_i=1, else to STOPBIT; ParityEnable_i is evaluated at that tick only.
REQ-022 PARITYBIT: the sample SHALL be XORed with the XOR of the data bits and ParityOdd_i; a nonzero result latches a parity-error flag; then STOPBIT.
REQ-023 STOPBIT, sample rx_s=1: on the next clk, Data_o SHALL take the shift register, p_DataValid_o SHALL pulse, p_ParityErr_o SHALL pulse if the flag is set, and the state SHALL go to IDLE.
REQ-024 STOPBIT, sample rx_s=0: on the next clk, p_FrameErr_o SHALL pulse, Data_o and p_DataValid_o SHALL stay unchanged/0, p_ParityErr_o SHALL stay 0, and the state SHALL go to IDLE.
REQ-025 Returning to IDLE at the stop-bit mid-sample allows a new start edge to be detected half a bit early; back-to-back frames SHALL be received without loss.
REQ-026 BitCounter_o SHALL be 0 in every state except DATABITS; it is 4 bits wide and never exceeds BITNUMBER.
REQ-027 State, bit counter and tick counter SHALL each be held in three copies and majority-voted; all copies update from the voted value.
REQ-028 A voted state that is not one-hot SHALL force all three copies to IDLE on the next clk.
REQ-029 Clock cycles without p_SampleSig_i SHALL leave all state unchanged except the synchronizer and the output pulses, which clear.

Reset
REQ-030 While rst=0: state copies = IDLE, counters = 0, shift register = 0, Data_o = 0x00, all pulses = 0, synchronizer = 1.
REQ-031 An assertion of rst in mid-frame SHALL abandon the frame; no pulse SHALL be emitted for it after release.

Verification
REQ-032 Frame 0xA5 at 16x ticks, no parity, stop=1 -> Data_o=0xA5, one p_DataValid_o pulse, no error pulses.
REQ-033 Even parity, byte 0x01, parity bit=1 -> Data_o=0x01 with valid; repeat with parity bit=0 -> valid plus p_ParityErr_o in the same cycle.
REQ-034 Low glitch of 4 ticks on Rx_i -> STARTBIT then IDLE, no pulses, Data_o unchanged.
REQ-035 Byte 0x3C with stop=0 -> p_FrameErr_o pulse, no valid, Data_o keeps its previous value.
REQ-036 rst pulled low after 3 data bits -> all outputs 0, IDLE; next clean frame 0x5A received correctly.
REQ-037 Force one state copy to STOPBIT during IDLE -> State_o stays IDLE; force all three copies to 00000 -> IDLE next clk.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// UART receiver FSM with oversampled bit timing, optional parity and
// triple-redundant voted state, bit counter and tick counter.
module uart_rx_fsm #(
  parameter int OVERSAMPLE = 16,
  parameter int BITNUMBER  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p_SampleSig_i,
  input  logic                 Rx_i,
  input  logic                 ParityEnable_i,
  input  logic                 ParityOdd_i,
  output logic [4:0]           State_o,
  output logic [3:0]           BitCounter_o,
  output logic [BITNUMBER-1:0] Data_o,
  output logic                 p_DataValid_o,
  output logic                 p_ParityErr_o,
  output logic                 p_FrameErr_o
);

  localparam int TW =
    (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    STARTBIT  = 5'b00010,
    DATABITS  = 5'b00100,
    PARITYBIT = 5'b01000,
    STOPBIT   = 5'b10000
  } state_t;

  localparam logic [TW-1:0] MID_START =
    TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] MID_BIT =
    TW'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_BIT =
    4'(BITNUMBER);

  logic                 rx_meta_q;
  logic                 rx_s_q;

  logic [4:0]           st0_q, st1_q, st2_q;
  logic [3:0]           bc0_q, bc1_q, bc2_q;
  logic [TW-1:0]        tk0_q, tk1_q, tk2_q;

  logic [4:0]           st_v, st_d;
  logic [3:0]           bc_v, bc_d;
  logic [TW-1:0]        tk_v, tk_d;
  logic                 st_ok;

  logic [BITNUMBER-1:0] shift_q, shift_d;
  logic [BITNUMBER-1:0] data_q, data_d;
  logic                 pflag_q, pflag_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  // Bitwise 2-of-3 majority over each redundant copy.
  assign st_v = (st0_q & st1_q)
              | (st0_q & st2_q)
              | (st1_q & st2_q);
  assign bc_v = (bc0_q & bc1_q)
              | (bc0_q & bc2_q)
              | (bc1_q & bc2_q);
  assign tk_v = (tk0_q & tk1_q)
              | (tk0_q & tk2_q)
              | (tk1_q & tk2_q);

  assign st_ok = (st_v != 5'd0) &&
                 ((st_v & (st_v - 5'd1)) == 5'd0);

  always_comb begin
    st_d    = st_v;
    bc_d    = bc_v;
    tk_d    = tk_v;
    shift_d = shift_q;
    data_d  = data_q;
    pflag_d = pflag_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    if (!st_ok) begin
      st_d = IDLE;
      bc_d = 4'd0;
      tk_d = '0;
    end else if (p_SampleSig_i) begin
      tk_d = (tk_v == MID_BIT) ? '0 : tk_v + 1'b1;
      unique case (1'b1)
        st_v[0]: begin
          if (!rx_s_q) begin
            st_d    = STARTBIT;
            pflag_d = 1'b0;
          end
        end
        st_v[1]: begin
          if (tk_v == MID_START) begin
            st_d = rx_s_q ? IDLE : DATABITS;
          end
        end
        st_v[2]: begin
          if (tk_v == MID_BIT) begin
            shift_d = {rx_s_q,
                       shift_q[BITNUMBER-1:1]};
            bc_d    = bc_v + 4'd1;
            if (bc_d == LAST_BIT) begin
              st_d = ParityEnable_i ?
                     PARITYBIT : STOPBIT;
            end
          end
        end
        st_v[3]: begin
          if (tk_v == MID_BIT) begin
            pflag_d = rx_s_q ^ (^shift_q)
                    ^ ParityOdd_i;
            st_d    = STOPBIT;
          end
        end
        st_v[4]: begin
          if (tk_v == MID_BIT) begin
            st_d = IDLE;
            if (rx_s_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              perr_d  = pflag_q;
            end else begin
              ferr_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
      // Leaving a state restarts bit timing.
      if (st_d != st_v) begin
        tk_d = '0;
      end
      if (st_d != DATABITS) begin
        bc_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= Rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st0_q <= IDLE;
      st1_q <= IDLE;
      st2_q <= IDLE;
      bc0_q <= 4'd0;
      bc1_q <= 4'd0;
      bc2_q <= 4'd0;
      tk0_q <= '0;
      tk1_q <= '0;
      tk2_q <= '0;
    end else begin
      st0_q <= st_d;
      st1_q <= st_d;
      st2_q <= st_d;
      bc0_q <= bc_d;
      bc1_q <= bc_d;
      bc2_q <= bc_d;
      tk0_q <= tk_d;
      tk1_q <= tk_d;
      tk2_q <= tk_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      data_q  <= '0;
      pflag_q <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      data_q  <= data_d;
      pflag_q <= pflag_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign State_o       = st_v;
  assign BitCounter_o  = bc_v;
  assign Data_o        = data_q;
  assign p_DataValid_o = valid_q;
  assign p_ParityErr_o = perr_q;
  assign p_FrameErr_o  = ferr_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed self-checking bench for uart_rx_fsm.
// Ticks every 2 clocks, 16 ticks per bit.
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic       pen = 1'b0;
  logic       podd = 1'b0;
  logic [4:0] state;
  logic [3:0] bcnt;
  logic [7:0] data;
  logic       valid, perr, ferr;

  int total = 0;
  int bad = 0;
  int n_valid = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int n_both = 0;

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_START = 5'b00010;
  localparam logic [4:0] S_DATA  = 5'b00100;

  uart_rx_fsm #(.OVERSAMPLE(16), .BITNUMBER(8)) dut (
    .clk(clk),
    .rst(rst),
    .p_SampleSig_i(tick),
    .Rx_i(rx),
    .ParityEnable_i(pen),
    .ParityOdd_i(podd),
    .State_o(state),
    .BitCounter_o(bcnt),
    .Data_o(data),
    .p_DataValid_o(valid),
    .p_ParityErr_o(perr),
    .p_FrameErr_o(ferr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) n_valid++;
    if (perr) n_perr++;
    if (ferr) n_ferr++;
    if (valid && perr) n_both++;
  end

  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (16) do_tick();
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic pe,
                            input logic pb,
                            input logic stop);
    pen = pe;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pe) send_bit(pb);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_bcnt", 32'(bcnt), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_pulses", 32'({valid, perr, ferr}), 0);
    rst = 1'b1;
    repeat (8) do_tick();
    chk("rst_idle_after", 32'(state), 32'(S_IDLE));
  endtask

  task automatic test_basic();
    int v0, p0, f0;
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    chk("a5_data", 32'(data), 32'h A5);
    chk("a5_valid", n_valid - v0, 1);
    chk("a5_perr", n_perr - p0, 0);
    chk("a5_ferr", n_ferr - f0, 0);
    chk("a5_state", 32'(state), 32'(S_IDLE));
  endtask

  task automatic test_parity();
    int v0, p0, b0;
    podd = 1'b0;
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    chk("ev_ok_data", 32'(data), 32'h01);
    chk("ev_ok_valid", n_valid - v0, 1);
    chk("ev_ok_perr", n_perr - p0, 0);
    v0 = n_valid; p0 = n_perr; b0 = n_both;
    send_frame(8'h01, 1'b1, 1'b0, 1'b1);
    chk("ev_bad_valid", n_valid - v0, 1);
    chk("ev_bad_perr", n_perr - p0, 1);
    chk("ev_bad_same", n_both - b0, 1);
    podd = 1'b1;
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    chk("odd_ok_data", 32'(data), 32'h03);
    chk("odd_ok_valid", n_valid - v0, 1);
    chk("odd_ok_perr", n_perr - p0, 0);
    podd = 1'b0;
    pen = 1'b0;
  endtask

  task automatic test_glitch();
    int v0, p0, f0;
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    rx = 1'b0;
    repeat (4) do_tick();
    chk("gl_start", 32'(state), 32'(S_START));
    rx = 1'b1;
    repeat (16) do_tick();
    chk("gl_idle", 32'(state), 32'(S_IDLE));
    chk("gl_pulses", n_valid - v0 + n_perr - p0
                     + n_ferr - f0, 0);
    chk("gl_data", 32'(data), 32'h03);
  endtask

  task automatic test_frame_err();
    int v0, p0, f0;
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (20) do_tick();
    chk("fe_ferr", n_ferr - f0, 1);
    chk("fe_valid", n_valid - v0, 0);
    chk("fe_perr", n_perr - p0, 0);
    chk("fe_data", 32'(data), 32'h03);
    chk("fe_idle", 32'(state), 32'(S_IDLE));
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = n_valid;
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    chk("b2b_first", 32'(data), 32'h12);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1);
    chk("b2b_second", 32'(data), 32'h34);
    chk("b2b_count", n_valid - v0, 2);
  endtask

  task automatic test_reset_mid_frame();
    int v0, p0, f0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("mf_bcnt", 32'(bcnt), 3);
    chk("mf_state", 32'(state), 32'(S_DATA));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk) rx = ~rx;
    end
    chk("hold_bcnt", 32'(bcnt), 3);
    chk("hold_state", 32'(state), 32'(S_DATA));
    @(negedge clk) rst = 1'b0;
    #1;
    chk("mf_rst_state", 32'(state), 32'(S_IDLE));
    chk("mf_rst_bcnt", 32'(bcnt), 0);
    chk("mf_rst_data", 32'(data), 0);
    chk("mf_rst_pulse", 32'({valid, perr, ferr}), 0);
    rx = 1'b1;
    @(negedge clk) rst = 1'b1;
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    repeat (200) do_tick();
    chk("mf_no_pulse", n_valid - v0 + n_perr - p0
                       + n_ferr - f0, 0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    chk("mf_5a_data", 32'(data), 32'h5A);
    chk("mf_5a_valid", n_valid - v0, 1);
  endtask

  task automatic test_tmr();
    @(negedge clk);
    force dut.st1_q = 5'b10000;
    repeat (4) do_tick();
    chk("tmr_one", 32'(state), 32'(S_IDLE));
    release dut.st1_q;
    @(negedge clk);
    force dut.st0_q = 5'b00000;
    force dut.st1_q = 5'b00000;
    force dut.st2_q = 5'b00000;
    #2;
    release dut.st0_q;
    release dut.st1_q;
    release dut.st2_q;
    @(posedge clk);
    #1;
    chk("tmr_zero", 32'(state), 32'(S_IDLE));
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    chk("tmr_frame", 32'(data), 32'hC3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_tmr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
